cubic_movavg: RTL and testbench
===============================

Name: cubic_movavg

Overview:
- Streaming moving-average stage placed directly downstream of the combinational cubic block.
- Consumes its signed Q4.6 samples (value = code/64) one per valid strobe.
- Keeps the last N samples in a circular buffer with a running sum.
- Emits the window average in the same Q4.6 format, so downstream logic sees a smoothed cubic response.

Parameters:
- W, 10, sample width in bits; input and output are signed Q4.6 at W=10.
- LOG2N, 3, log2 of the window length; N = 2**LOG2N = 8.
- SW, W+LOG2N, accumulator width (derived localparam, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous flush of window contents; same effect as reset on state.
- in_valid  in  1  in_data is a new sample this cycle.
- in_data  in  W  signed sample, Q4.6.
- out_valid  out  1  out_data is updated this cycle (one-cycle pulse per accepted sample).
- out_data  out  W  signed window average, Q4.6.
- out_full  out  1  window holds N real samples since the last reset or clear.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: out_valid=0, out_data=0, out_full=0, all buffer entries=0, write pointer=0, fill count=0, accumulator=0.
- Accept rule:
  - A sample is accepted at a rising edge where in_valid=1 and reset=0 and clear=0.
  - There is no backpressure; every sample is accepted.
- Update on accept:
  - sum_next = sum + in_data - buf[wp].
  - buf[wp] = in_data.
  - wp = wp+1, wrapping modulo N.
  - count = min(count+1, N).
- Output:
  - Registered; latency is 1 cycle.
  - The edge that accepts a sample sets out_valid=1 and out_data = sum_next >>> LOG2N.
  - The shift is arithmetic: floor, rounding toward minus infinity.
- Arithmetic and width:
  - Sum is signed SW bits; in_data is sign-extended to SW before add/sub.
  - Overflow is impossible: |sum| <= N*2^(W-1).
  - The shifted result always fits W bits and is truncated to W bits with no saturation.
- Partial window: empty slots are zero, so until N samples arrive, out_data = (sum of received samples)/N, not /count.
- out_full:
  - Goes to 1 on the edge that accepts the Nth sample, together with out_valid for that sample.
  - Stays 1 until reset or clear.
- Idle cycles (in_valid=0): out_valid=0; out_data, out_full and all internal state hold.
- clear: acts identically to reset on all state and outputs.
- Priority: reset > clear > in_valid. An in_valid sample coincident with reset or clear is discarded and produces no out_valid.
- Pointer wrap: wp goes N-1 -> 0 with no gap; back-to-back in_valid every cycle is fully supported.
- Reset mid-stream: the next accepted sample behaves exactly as the first sample after power-up.

Decomposition:
- Package cubic_pkg holds:
  - Q-format constants: Q_IN_FRAC=7, Q_OUT_FRAC=6, OUT_W=10.
  - A localparam for the default LOG2N, shared with the cubic testbench.
- One sub-module, cubic_movavg_ring:
  - Contents: N x W register array, write pointer, and old-sample read-before-write port.
  - Placement: instantiated once; the accumulator and output registers stay in the top.

Test Plan:
- Reset held 3 cycles with in_valid=1 and in_data=0x040 -> out_valid=0, out_data=0x000, out_full=0 throughout; no sample retained.
- Ramp-up: after reset, 8 back-to-back samples 0x040 (+1.0) -> out_data 0x008, 0x010, 0x018, 0x020, 0x028, 0x030, 0x038, 0x040 on consecutive cycles.
  - out_full rises with the 8th output.
- Wrap and replace: continue with 8 samples 0x3C0 (-1.0) -> out_data 0x030, 0x020, 0x010, 0x000, 0x3F0, 0x3E0, 0x3D0, 0x3C0.
  - out_full stays 1.
- Floor and extremes:
  - After reset, a single 0x3FF (-1 LSB) -> out_data=0x3FF.
  - After reset, 8 x 0x1FF -> final out_data=0x1FF.
  - After reset, 8 x 0x200 -> final out_data=0x200; no overflow.
- Gapped input: samples 0x040 with in_valid on alternate cycles -> out_valid pulses only on the cycle after each accepted sample.
  - out_data holds between pulses; values match the ramp-up sequence.
- Clear mid-stream: after 5 samples of 0x040, assert clear with in_valid=1 carrying 0x1FF -> no out_valid; out_data=0 and out_full=0.
  - The next sample 0x040 gives out_data=0x008, confirming the 0x1FF sample was discarded.

Source files
------------

// File: rtl/cubic_pkg.sv
// Shared constants for the cubic datapath and its smoothing stage.
// Q-format widths and the default moving-average window size.
package cubic_pkg;

    localparam int Q_IN_FRAC    = 7;
    localparam int Q_OUT_FRAC   = 6;
    localparam int OUT_W        = 10;
    localparam int MOVAVG_LOG2N = 3;

endpackage

// File: rtl/cubic_movavg_ring.sv
// Circular sample store for the moving average.
// Presents the sample about to be overwritten so the sum can retire it.
module cubic_movavg_ring
    import cubic_pkg::*;
#(
    parameter int W     = OUT_W,
    parameter int LOG2N = MOVAVG_LOG2N
) (
    input  logic         clk,
    input  logic         flush,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] old_data
);

    localparam int N = 1 << LOG2N;

    logic [W-1:0]     mem [N];
    logic [LOG2N-1:0] wp;

    assign old_data = mem[wp];

    // N is a power of two, so the pointer wraps on its own.
    always_ff @(posedge clk) begin
        if (flush) begin
            wp <= '0;
            for (int i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wp] <= wr_data;
            wp      <= wp + 1'b1;
        end
    end

endmodule

// File: rtl/cubic_movavg.sv
// Moving average over the last 2**LOG2N signed Q4.6 samples.
// Registered output, one pulse per accepted sample, floor rounding.
module cubic_movavg
    import cubic_pkg::*;
#(
    parameter int W     = OUT_W,
    parameter int LOG2N = MOVAVG_LOG2N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_full
);

    localparam int SW = W + LOG2N;
    localparam int N  = 1 << LOG2N;
    localparam logic [LOG2N:0] CNT_MAX = (LOG2N + 1)'(N);

    logic                 flush;
    logic                 accept;
    logic [W-1:0]         old_data;
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] sum_next;
    logic signed [SW-1:0] in_ext;
    logic signed [SW-1:0] old_ext;
    logic [LOG2N:0]       count;
    logic [LOG2N:0]       count_next;

    assign flush  = reset | clear;
    assign accept = in_valid & ~flush;

    assign in_ext  = {{LOG2N{in_data[W-1]}}, in_data};
    assign old_ext = {{LOG2N{old_data[W-1]}}, old_data};

    // Empty slots hold zero, so retiring them is harmless during fill.
    assign sum_next   = sum + in_ext - old_ext;
    assign count_next = (count == CNT_MAX) ? count : count + 1'b1;

    cubic_movavg_ring #(
        .W     (W),
        .LOG2N (LOG2N)
    ) u_ring (
        .clk      (clk),
        .flush    (flush),
        .wr_en    (accept),
        .wr_data  (in_data),
        .old_data (old_data)
    );

    // Upper W bits of the sum are the floor of sum / N.
    always_ff @(posedge clk) begin
        if (flush) begin
            sum       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_full  <= 1'b0;
        end else if (accept) begin
            sum       <= sum_next;
            count     <= count_next;
            out_valid <= 1'b1;
            out_data  <= sum_next[SW-1:LOG2N];
            out_full  <= (count_next == CNT_MAX);
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cubic_movavg.sv
// Self-checking bench for cubic_movavg against a sample-history model.
// Directed scenarios plus a randomized stream with occasional flushes.
module tb_cubic_movavg;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         clear = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_full;

    int checks = 0;
    int errors = 0;

    int           hist[$];
    logic         exp_valid = 1'b0;
    logic [W-1:0] exp_data = '0;
    logic         exp_full = 1'b0;

    always #5 clk = ~clk;

    cubic_movavg dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_full  (out_full)
    );

    // Model: average of the last 8 samples, missing samples count as zero.
    task automatic model_update(input logic r, input logic c,
                                input logic v, input logic [W-1:0] d);
        int s;
        if (r || c) begin
            hist.delete();
            exp_valid = 1'b0;
            exp_data  = '0;
            exp_full  = 1'b0;
        end else if (v) begin
            hist.push_back(int'($signed(d)));
            if (hist.size() > 8) void'(hist.pop_front());
            s = 0;
            foreach (hist[i]) s += hist[i];
            exp_valid = 1'b1;
            exp_data  = W'(s >>> 3);
            exp_full  = (hist.size() == 8);
        end else begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic step(input logic r, input logic c,
                        input logic v, input logic [W-1:0] d);
        reset    = r;
        clear    = c;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
        model_update(r, c, v, d);
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, 10'h040);
            checks++;
            if (out_valid !== 1'b0 || out_data !== 10'h000 || out_full !== 1'b0) begin
                errors++;
                $display("FAIL reset cyc%0d got v=%b d=%h f=%b exp 0 000 0",
                         i, out_valid, out_data, out_full);
            end
        end
        step(1'b0, 1'b0, 1'b1, 10'h040);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 10'h008) begin
            errors++;
            $display("FAIL reset_retain got v=%b d=%h exp 1 008", out_valid, out_data);
        end
    endtask

    task automatic test_ramp_wrap;
        logic [W-1:0] up [8] = '{10'h008, 10'h010, 10'h018, 10'h020,
                                 10'h028, 10'h030, 10'h038, 10'h040};
        logic [W-1:0] dn [8] = '{10'h030, 10'h020, 10'h010, 10'h000,
                                 10'h3F0, 10'h3E0, 10'h3D0, 10'h3C0};
        step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, 10'h040);
            checks++;
            if (out_valid !== 1'b1 || out_data !== up[i] || out_full !== (i == 7)) begin
                errors++;
                $display("FAIL ramp%0d got v=%b d=%h f=%b exp 1 %h %b",
                         i, out_valid, out_data, out_full, up[i], i == 7);
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, 10'h3C0);
            checks++;
            if (out_valid !== 1'b1 || out_data !== dn[i] || out_full !== 1'b1) begin
                errors++;
                $display("FAIL wrap%0d got v=%b d=%h f=%b exp 1 %h 1",
                         i, out_valid, out_data, out_full, dn[i]);
            end
        end
    endtask

    task automatic test_extremes;
        logic [W-1:0] vals [3] = '{10'h3FF, 10'h1FF, 10'h200};
        logic [W-1:0] want [3] = '{10'h3FF, 10'h1FF, 10'h200};
        int           reps [3] = '{1, 8, 8};
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b0, '0);
            for (int i = 0; i < reps[k]; i++) step(1'b0, 1'b0, 1'b1, vals[k]);
            checks++;
            if (out_data !== want[k] || out_data !== exp_data) begin
                errors++;
                $display("FAIL extreme%0d got %h exp %h", k, out_data, want[k]);
            end
        end
    endtask

    task automatic test_gapped;
        step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, (i % 2) == 0, 10'h040);
            checks++;
            if (out_valid !== exp_valid || out_data !== exp_data || out_full !== exp_full) begin
                errors++;
                $display("FAIL gapped%0d got v=%b d=%h f=%b exp %b %h %b",
                         i, out_valid, out_data, out_full, exp_valid, exp_data, exp_full);
            end
        end
        checks++;
        if (out_data !== 10'h040 || out_full !== 1'b1) begin
            errors++;
            $display("FAIL gapped_end got d=%h f=%b exp 040 1", out_data, out_full);
        end
    endtask

    task automatic test_clear;
        step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 10'h040);
        step(1'b0, 1'b1, 1'b1, 10'h1FF);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 10'h000 || out_full !== 1'b0) begin
            errors++;
            $display("FAIL clear got v=%b d=%h f=%b exp 0 000 0",
                     out_valid, out_data, out_full);
        end
        step(1'b0, 1'b0, 1'b1, 10'h040);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 10'h008) begin
            errors++;
            $display("FAIL clear_next got v=%b d=%h exp 1 008", out_valid, out_data);
        end
    endtask

    task automatic test_random;
        logic r, c, v;
        step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 99) < 2);
            c = ($urandom_range(0, 99) < 3);
            v = ($urandom_range(0, 99) < 75);
            step(r, c, v, W'($urandom));
            checks++;
            if (out_valid !== exp_valid || out_data !== exp_data || out_full !== exp_full) begin
                errors++;
                $display("FAIL rand%0d got v=%b d=%h f=%b exp %b %h %b",
                         i, out_valid, out_data, out_full, exp_valid, exp_data, exp_full);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp_wrap();
        test_extremes();
        test_gapped();
        test_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
